zoom_wr_arb: RTL and testbench

- Arbitrates the DDR3 write port between two zoom-scaler write channels (VGA-A, VGA-B) in the clk_100M domain.
- Each channel presents a burst request, packet address, frame index and a 240-bit data stream released by a one-cycle rden pulse.
- Selects a winner round-robin, issues the DDR3 write command, releases the winner's burst, then forwards exactly BURST beats to the DDR3 write-data port.

---
 rtl/zoom_wr_arb.sv | 167 ++++++++++++++++
 tb/tb_zoom_wr_arb.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/zoom_wr_arb.sv
// zoom_wr_arb: round-robin arbiter giving two zoom-scaler write channels access to the DDR3 write port.
// Optional watchdog abort from CMD/DATA is compiled in with ZOOM_ARB_TIMEOUT_EN.
module zoom_wr_arb #(
  parameter int DW    = 240,
  parameter int AW    = 16,
  parameter int BURST = 16,
  parameter int TMO   = 64
) (
  input  logic          clk_100M,
  input  logic          rst,
  input  logic          a_req,
  input  logic [AW-1:0] a_addr,
  input  logic [1:0]    a_frame,
  input  logic          a_vld,
  input  logic [DW-1:0] a_data,
  output logic          a_rden,
  input  logic          b_req,
  input  logic [AW-1:0] b_addr,
  input  logic [1:0]    b_frame,
  input  logic          b_vld,
  input  logic [DW-1:0] b_data,
  output logic          b_rden,
  output logic          ddr_wr_req,
  output logic [AW-1:0] ddr_wr_addr,
  output logic [1:0]    ddr_wr_frame,
  output logic          ddr_wr_ch,
  input  logic          ddr_wr_ack,
  output logic [DW-1:0] ddr_wdata,
  output logic          ddr_wdata_vld,
`ifdef ZOOM_ARB_TIMEOUT_EN
  output logic          tmo_err,
`endif
  output logic          busy,
  output logic          err_stray
);

  localparam int CW = $clog2(BURST) + 1;

  typedef enum logic [2:0] {IDLE, CMD, GRANT, DATA, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    frame_q, frame_d;
  logic          ch_q, ch_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          wvld_q, wvld_d;
  logic          stray_q, stray_d;
  logic          win_vld, lose_vld;

`ifdef ZOOM_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TMO + 1);
  logic [WW-1:0] wd_q, wd_d;
  logic          progress, tmo_hit;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    frame_d  = frame_q;
    ch_d     = ch_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    wdata_d  = wdata_q;
    wvld_d   = 1'b0;
    stray_d  = stray_q;
    win_vld  = ch_q ? b_vld : a_vld;
    lose_vld = ch_q ? a_vld : b_vld;

    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          // On a tie the channel that did not win last time goes next.
          ch_d    = (a_req && b_req) ? ~last_q : b_req;
          addr_d  = ch_d ? b_addr  : a_addr;
          frame_d = ch_d ? b_frame : a_frame;
          state_d = CMD;
        end
      end
      CMD: begin
        if (ddr_wr_ack) state_d = GRANT;
      end
      GRANT: begin
        cnt_d   = '0;
        state_d = DATA;
      end
      DATA: begin
        if (win_vld) begin
          wvld_d  = 1'b1;
          wdata_d = ch_q ? b_data : a_data;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(BURST - 1)) state_d = DONE;
        end
        if (lose_vld) stray_d = 1'b1;
      end
      DONE: begin
        last_d  = ch_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != DATA && (a_vld || b_vld)) stray_d = 1'b1;

`ifdef ZOOM_ARB_TIMEOUT_EN
    tmo_hit  = 1'b0;
    wd_d     = '0;
    progress = (state_q == CMD && ddr_wr_ack) || (state_q == DATA && win_vld);
    if ((state_q == CMD || state_q == DATA) && !progress) begin
      // Abort leaves last_grant alone so the stalled channel keeps its turn.
      if (wd_q == WW'(TMO - 1)) begin
        tmo_hit = 1'b1;
        stray_d = 1'b1;
        state_d = IDLE;
      end else begin
        wd_d = wd_q + WW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      frame_q <= '0;
      ch_q    <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      wdata_q <= '0;
      wvld_q  <= 1'b0;
      stray_q <= 1'b0;
`ifdef ZOOM_ARB_TIMEOUT_EN
      wd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      frame_q <= frame_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      wvld_q  <= wvld_d;
      stray_q <= stray_d;
`ifdef ZOOM_ARB_TIMEOUT_EN
      wd_q    <= wd_d;
`endif
    end
  end

  assign a_rden        = (state_q == GRANT) && !ch_q;
  assign b_rden        = (state_q == GRANT) &&  ch_q;
  assign ddr_wr_req    = (state_q == CMD);
  assign ddr_wr_addr   = addr_q;
  assign ddr_wr_frame  = frame_q;
  assign ddr_wr_ch     = ch_q;
  assign ddr_wdata     = wdata_q;
  assign ddr_wdata_vld = wvld_q;
  assign busy          = (state_q != IDLE);
  assign err_stray     = stray_q;
`ifdef ZOOM_ARB_TIMEOUT_EN
  assign tmo_err       = tmo_hit;
`endif

endmodule

// File: tb/tb_zoom_wr_arb.sv
// Scoreboard bench for zoom_wr_arb: command and data expectations are queued when driven, compared when seen.
module tb_zoom_wr_arb;

  localparam int DW    = 240;
  localparam int AW    = 16;
  localparam int BURST = 16;

  logic          clk_100M, rst;
  logic          a_req, a_vld, a_rden, b_req, b_vld, b_rden;
  logic [AW-1:0] a_addr, b_addr, ddr_wr_addr;
  logic [1:0]    a_frame, b_frame, ddr_wr_frame;
  logic [DW-1:0] a_data, b_data, ddr_wdata;
  logic          ddr_wr_req, ddr_wr_ch, ddr_wr_ack, ddr_wdata_vld, busy, err_stray;
`ifdef ZOOM_ARB_TIMEOUT_EN
  logic          tmo_err;
`endif

  zoom_wr_arb dut (
    .clk_100M(clk_100M), .rst(rst),
    .a_req(a_req), .a_addr(a_addr), .a_frame(a_frame), .a_vld(a_vld), .a_data(a_data), .a_rden(a_rden),
    .b_req(b_req), .b_addr(b_addr), .b_frame(b_frame), .b_vld(b_vld), .b_data(b_data), .b_rden(b_rden),
    .ddr_wr_req(ddr_wr_req), .ddr_wr_addr(ddr_wr_addr), .ddr_wr_frame(ddr_wr_frame),
    .ddr_wr_ch(ddr_wr_ch), .ddr_wr_ack(ddr_wr_ack), .ddr_wdata(ddr_wdata),
    .ddr_wdata_vld(ddr_wdata_vld),
`ifdef ZOOM_ARB_TIMEOUT_EN
    .tmo_err(tmo_err),
`endif
    .busy(busy), .err_stray(err_stray)
  );

  initial clk_100M = 1'b0;
  always #5 clk_100M = ~clk_100M;

  int n_vec = 0;
  int n_err = 0;
  int req_tot = 0, ar_tot = 0, br_tot = 0, beat_tot = 0;
  logic req_prev = 1'b0;
  logic [AW+2:0] cmd_q[$];
  logic [DW-1:0] sb_q[$];

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int i, input bit cnt);
    logic [255:0] t;
    if (cnt) return DW'(i);
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  // One clock: sample DUT outputs mid-cycle, then move to just after the next edge.
  task automatic tick();
    logic [AW+2:0] c;
    logic [DW-1:0] d;
    @(negedge clk_100M);
    if (ddr_wr_req && !req_prev) begin
      if (cmd_q.size() == 0) chk("cmd_extra", 256'(cmd_q.size()), 256'(1));
      else begin
        c = cmd_q.pop_front();
        chk("cmd_fields", 256'({ddr_wr_addr, ddr_wr_frame, ddr_wr_ch}), 256'(c));
      end
    end
    req_prev = ddr_wr_req;
    if (ddr_wr_req) req_tot++;
    if (a_rden) ar_tot++;
    if (b_rden) br_tot++;
    if (ddr_wdata_vld) begin
      beat_tot++;
      if (sb_q.size() == 0) chk("extra_beat", 256'(sb_q.size()), 256'(1));
      else begin
        d = sb_q.pop_front();
        chk("wdata", 256'(ddr_wdata), 256'(d));
      end
    end
    @(posedge clk_100M);
    #1;
  endtask

  task automatic do_rst();
    rst = 1'b1; a_vld = 1'b0; b_vld = 1'b0; ddr_wr_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    cmd_q.delete();
    sb_q.delete();
  endtask

  // Serve one packet expected to be won by channel ch; reqs are set by the caller.
  task automatic serve(input bit ch, input int ack_dly, input int gap, input bit keep_req,
                       input bit cnt, input int stray_at, input int rst_at);
    int r0, a0, b0, w0, n;
    logic [DW-1:0] d;
    cmd_q.push_back(ch ? {b_addr, b_frame, 1'b1} : {a_addr, a_frame, 1'b0});
    n = 0;
    while (!ddr_wr_req && n < 20) begin tick(); n++; end
    if (!ddr_wr_req) begin chk("cmd_wait", 256'(ddr_wr_req), 256'(1)); return; end
    r0 = req_tot; a0 = ar_tot; b0 = br_tot;
    repeat (ack_dly) tick();
    ddr_wr_ack = 1'b1;
    tick();
    ddr_wr_ack = 1'b0;
    chk("req_cycles", 256'(req_tot - r0), 256'(ack_dly + 1));
    chk("rden_win", 256'(ch ? b_rden : a_rden), 256'(1));
    chk("rden_lose", 256'(ch ? a_rden : b_rden), 256'(0));
    if (!keep_req) begin if (ch) b_req = 1'b0; else a_req = 1'b0; end
    tick();
    w0 = beat_tot;
    for (int i = 0; i < BURST; i++) begin
      if (i == rst_at) begin
        rst = 1'b1; a_req = 1'b0; b_req = 1'b0;
        tick();
        rst = 1'b0;
        chk("rst_ctl", 256'({busy, ddr_wr_req, ddr_wdata_vld, a_rden, b_rden, ddr_wr_ch, err_stray}), 256'(0));
        chk("rst_cmd", 256'({ddr_wr_addr, ddr_wr_frame}), 256'(0));
        chk("rst_data", 256'(ddr_wdata), 256'(0));
        return;
      end
      d = mk(i + 1, cnt);
      if (ch) begin b_vld = 1'b1; b_data = d; end
      else begin a_vld = 1'b1; a_data = d; end
      if (i == stray_at) begin if (ch) a_vld = 1'b1; else b_vld = 1'b1; end
      sb_q.push_back(d);
      tick();
      a_vld = 1'b0; b_vld = 1'b0;
      if (i < BURST - 1) begin
        chk("busy_data", 256'(busy), 256'(1));
        repeat (gap) tick();
      end
    end
    chk("busy_done", 256'(busy), 256'(1));
    tick();
    chk("busy_idle", 256'(busy), 256'(0));
    chk("beats", 256'(beat_tot - w0), 256'(BURST));
    chk("rden_cnt_win", 256'(ch ? br_tot - b0 : ar_tot - a0), 256'(1));
    chk("rden_cnt_lose", 256'(ch ? ar_tot - a0 : br_tot - b0), 256'(0));
  endtask

  initial begin
    rst = 1'b0; ddr_wr_ack = 1'b0;
    a_req = 1'b0; a_addr = '0; a_frame = '0; a_vld = 1'b0; a_data = '0;
    b_req = 1'b0; b_addr = '0; b_frame = '0; b_vld = 1'b0; b_data = '0;
    do_rst();
    chk("reset_ctl", 256'({busy, ddr_wr_req, ddr_wdata_vld, a_rden, b_rden, ddr_wr_ch, err_stray}), 256'(0));
    chk("reset_cmd", 256'({ddr_wr_addr, ddr_wr_frame}), 256'(0));

    // Single A packet, ack after 3 cycles, counting data.
    a_addr = 16'h4BF3; a_frame = 2'd2; a_req = 1'b1;
    serve(1'b0, 3, 0, 1'b0, 1'b1, -1, -1);

    // Both held: strict alternation starting with A.
    do_rst();
    a_addr = 16'h1234; a_frame = 2'd1; b_addr = 16'hBEEF; b_frame = 2'd3;
    a_req = 1'b1; b_req = 1'b1;
    serve(1'b0, 0, 0, 1'b1, 1'b0, -1, -1);
    serve(1'b1, 0, 0, 1'b1, 1'b0, -1, -1);
    serve(1'b0, 0, 0, 1'b1, 1'b0, -1, -1);
    serve(1'b1, 0, 0, 1'b1, 1'b0, -1, -1);
    a_req = 1'b0; b_req = 1'b0;

    // B alone first, then a tie goes to A.
    do_rst();
    b_addr = 16'h0F0F; b_frame = 2'd3; b_req = 1'b1;
    serve(1'b1, 1, 0, 1'b0, 1'b0, -1, -1);
    a_addr = 16'h7001; a_frame = 2'd1; a_req = 1'b1; b_req = 1'b1;
    serve(1'b0, 2, 0, 1'b1, 1'b0, -1, -1);
    serve(1'b1, 0, 0, 1'b1, 1'b0, -1, -1);
    a_req = 1'b0; b_req = 1'b0;

    // Gapped beats (1,0,0,...).
    a_addr = 16'h00A5; a_frame = 2'd2; a_req = 1'b1;
    serve(1'b0, 1, 2, 1'b0, 1'b0, -1, -1);
    chk("stray_clear", 256'(err_stray), 256'(0));

    // Loser vld during DATA, then a_vld in IDLE.
    a_req = 1'b1;
    serve(1'b0, 0, 1, 1'b0, 1'b0, 5, -1);
    chk("stray_loser", 256'(err_stray), 256'(1));
    a_vld = 1'b1; a_data = mk(0, 1'b0);
    tick();
    a_vld = 1'b0;
    tick(); tick();
    chk("idle_vld_beats", 256'(sb_q.size()), 256'(0));
    chk("stray_sticky", 256'(err_stray), 256'(1));
    chk("idle_busy", 256'(busy), 256'(0));
    do_rst();
    chk("stray_rst", 256'(err_stray), 256'(0));

    // Reset mid-burst, then a fresh packet.
    a_addr = 16'h5A5A; a_frame = 2'd1; a_req = 1'b1;
    serve(1'b0, 0, 0, 1'b0, 1'b0, -1, 7);
    cmd_q.delete(); sb_q.delete();
    a_addr = 16'h6B6B; a_frame = 2'd3; a_req = 1'b1;
    serve(1'b0, 1, 0, 1'b0, 1'b1, -1, -1);

`ifdef ZOOM_ARB_TIMEOUT_EN
    begin
      int n;
      do_rst();
      a_addr = 16'h2222; a_frame = 2'd2; a_req = 1'b1;
      cmd_q.push_back({a_addr, a_frame, 1'b0});
      n = 0;
      while (!ddr_wr_req && n < 20) begin tick(); n++; end
      n = 0;
      while (!tmo_err && n < 100) begin tick(); n++; end
      chk("tmo_cycle", 256'(n + 1), 256'(64));
      a_req = 1'b0;
      tick();
      chk("tmo_stray", 256'(err_stray), 256'(1));
      chk("tmo_idle", 256'({busy, tmo_err}), 256'(0));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
